// File: rtl/tohost_monitor.sv
// End-of-test monitor for the riscv-tests flow: snoops the core's store port for
// the tohost verdict, and also flags a cycle-budget timeout or a stuck PC.
module tohost_monitor #(
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
   parameter int unsigned TIMEOUT     = 5000,
   parameter int unsigned STALL_LIMIT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] pc,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic        hung,
   output logic [30:0] test_num,
   output logic [31:0] tohost_value,
   output logic [31:0] cycles
);

   localparam int unsigned SW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
   localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);
   localparam logic [31:0] TIMEOUT_M1 = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TIMEOUT,
      ST_HUNG
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   cycles_nxt;
   logic [31:0]   tohost_nxt;
   logic [30:0]   test_num_nxt;
   logic [31:0]   pc_q;
   logic          pc_vld;
   logic [SW-1:0] stall_cnt, stall_nxt;
   logic          tohost_wr, verdict_wr;
   logic          timeout_hit, hung_hit;
   logic [31:0]   cycles_inc;

   assign tohost_wr  = mem_we && (mem_addr == TOHOST_ADDR);
   assign verdict_wr = tohost_wr && mem_wdata[0];
   assign cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

   // pc_vld masks the first edge after reset, when pc_q holds no real PC yet
   always_comb begin
      stall_nxt = '0;
      if (!tohost_wr && pc_vld && (pc == pc_q))
         stall_nxt = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
   end

   assign timeout_hit = (TIMEOUT != 0) && (cycles == TIMEOUT_M1);
   assign hung_hit    = (STALL_LIMIT != 0) && (stall_nxt == STALL_MAX);

   // Verdict beats timeout beats hang; only the timeout edge itself is counted
   always_comb begin
      state_nxt    = state;
      cycles_nxt   = cycles;
      tohost_nxt   = tohost_value;
      test_num_nxt = test_num;
      if (state == ST_RUN) begin
         cycles_nxt = cycles_inc;
         if (verdict_wr) begin
            cycles_nxt = cycles;
            tohost_nxt = mem_wdata;
            if (mem_wdata == 32'd1) begin
               state_nxt = ST_PASS;
            end else begin
               state_nxt    = ST_FAIL;
               test_num_nxt = mem_wdata[31:1];
            end
         end else if (timeout_hit) begin
            state_nxt = ST_TIMEOUT;
         end else if (hung_hit) begin
            state_nxt  = ST_HUNG;
            cycles_nxt = cycles;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_RUN;
         cycles       <= '0;
         tohost_value <= '0;
         test_num     <= '0;
         pc_q         <= '0;
         pc_vld       <= 1'b0;
         stall_cnt    <= '0;
      end else begin
         state        <= state_nxt;
         cycles       <= cycles_nxt;
         tohost_value <= tohost_nxt;
         test_num     <= test_num_nxt;
         pc_q         <= pc;
         pc_vld       <= 1'b1;
         stall_cnt    <= stall_nxt;
      end
   end

   assign pass    = (state == ST_PASS);
   assign fail    = (state == ST_FAIL);
   assign timeout = (state == ST_TIMEOUT);
   assign hung    = (state == ST_HUNG);
   assign done    = (state != ST_RUN);

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: a vector table for store decoding plus
// hand sequences for pass hold, timeout, hang and asynchronous reset.
module tb_tohost_monitor;

   localparam int unsigned TO = 120;
   localparam int unsigned SL = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] pc = '0;
   logic        done, pass, fail, timeout, hung;
   logic [30:0] test_num;
   logic [31:0] tohost_value, cycles;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] pcv;

   tohost_monitor #(.TOHOST_ADDR(32'h0000_1000), .TIMEOUT(TO), .STALL_LIMIT(SL)) dut (
      .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .pc(pc), .done(done), .pass(pass), .fail(fail),
      .timeout(timeout), .hung(hung), .test_num(test_num),
      .tohost_value(tohost_value), .cycles(cycles)
   );

   always #5 clk = ~clk;

   // flags packed as {done, pass, fail, timeout, hung}
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [4:0]  flags;
      logic [30:0] tn;
      logic [31:0] tv;
      logic [31:0] cyc;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string nm, input logic [4:0] ef, input logic [30:0] etn,
                        input logic [31:0] etv, input logic [31:0] ecyc);
      logic [4:0] af;
      af = {done, pass, fail, timeout, hung};
      n_vec++;
      if (af !== ef || test_num !== etn || tohost_value !== etv || cycles !== ecyc) begin
         n_err++;
         $display("FAIL %s: got flags=%b test_num=%h tohost=%h cycles=%0d, want flags=%b test_num=%h tohost=%h cycles=%0d",
                  nm, af, test_num, tohost_value, cycles, ef, etn, etv, ecyc);
      end
   endtask

   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p);
      @(negedge clk);
      mem_we = we; mem_addr = a; mem_wdata = d; pc = p;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         pcv = pcv + 32'd4;
         step(1'b0, 32'h0, 32'h0, pcv);
      end
   endtask

   task automatic do_reset();
      mem_we = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", 5'b00000, 31'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      pcv = 32'h100;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b0, 32'h0000_0000, 32'h0, 32'h100, 5'b00000, 31'd0, 32'd0, 32'd1};
      tbl[1] = '{1'b0, 32'h0000_0000, 32'h0, 32'h104, 5'b00000, 31'd0, 32'd0, 32'd2};
      tbl[2] = '{1'b1, 32'h0000_1000, 32'h2, 32'h108, 5'b00000, 31'd0, 32'd0, 32'd3};
      tbl[3] = '{1'b1, 32'h0000_1004, 32'h1, 32'h10c, 5'b00000, 31'd0, 32'd0, 32'd4};
      tbl[4] = '{1'b0, 32'h0000_1000, 32'h1, 32'h110, 5'b00000, 31'd0, 32'd0, 32'd5};
      tbl[5] = '{1'b1, 32'h0000_1000, 32'h7, 32'h114, 5'b10100, 31'd3, 32'd7, 32'd5};
      tbl[6] = '{1'b1, 32'h0000_1000, 32'h1, 32'h118, 5'b10100, 31'd3, 32'd7, 32'd5};
      tbl[7] = '{1'b0, 32'h0000_0000, 32'h0, 32'h118, 5'b10100, 31'd3, 32'd7, 32'd5};

      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].pc);
         check($sformatf("tbl[%0d]", i), tbl[i].flags, tbl[i].tn, tbl[i].tv, tbl[i].cyc);
      end

      // pass after 100 counted edges, then held
      do_reset();
      idle(100);
      check("pre_pass", 5'b00000, 31'd0, 32'd0, 32'd100);
      step(1'b1, 32'h0000_1000, 32'h1, pcv + 32'd4);
      check("pass", 5'b11000, 31'd0, 32'd1, 32'd100);
      for (int i = 0; i < 50; i++) begin
         idle(1);
         check("pass_hold", 5'b11000, 31'd0, 32'd1, 32'd100);
      end

      // timeout with a toggling pc
      do_reset();
      idle(TO - 1);
      check("pre_timeout", 5'b00000, 31'd0, 32'd0, 32'(TO - 1));
      idle(1);
      check("timeout", 5'b10010, 31'd0, 32'd0, 32'(TO));
      idle(3);
      check("timeout_hold", 5'b10010, 31'd0, 32'd0, 32'(TO));

      // verdict on the timeout edge wins
      do_reset();
      idle(TO - 1);
      step(1'b1, 32'h0000_1000, 32'h1, pcv + 32'd4);
      check("pass_vs_timeout", 5'b11000, 31'd0, 32'd1, 32'(TO - 1));

      // syscall first, then pass; then async reset and a fail after release
      do_reset();
      step(1'b1, 32'h0000_1000, 32'h2, 32'h200);
      check("syscall_ignored", 5'b00000, 31'd0, 32'd0, 32'd1);
      step(1'b1, 32'h0000_1000, 32'h1, 32'h204);
      check("pass_after_syscall", 5'b11000, 31'd0, 32'd1, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", 5'b00000, 31'd0, 32'd0, 32'd0);
      do_reset();
      idle(3);
      step(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, pcv + 32'd4);
      check("fail_max", 5'b10100, 31'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd3);

      // pc stuck from release: the first edge does not count as a stall
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 32'h40);
      check("pre_hung", 5'b00000, 31'd0, 32'd0, 32'd8);
      step(1'b0, 32'h0, 32'h0, 32'h40);
      check("hung", 5'b10001, 31'd0, 32'd0, 32'd8);

      // pc change restarts the stall count
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 32'h0, 32'h40);
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 32'h44);
      check("hung_restart_pre", 5'b00000, 31'd0, 32'd0, 32'd15);
      step(1'b0, 32'h0, 32'h0, 32'h44);
      check("hung_restart", 5'b10001, 31'd0, 32'd0, 32'd15);

      // a tohost write clears the stall count
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 32'h40);
      step(1'b1, 32'h0000_1000, 32'h2, 32'h40);
      for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 32'h0, 32'h40);
      check("hung_clr_pre", 5'b00000, 31'd0, 32'd0, 32'd12);
      step(1'b0, 32'h0, 32'h0, 32'h40);
      check("hung_clr", 5'b10001, 31'd0, 32'd0, 32'd12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
